// File: rtl/at_hazard_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | at_hazard_pkg : shared result-source / forward-select codes        |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package at_hazard_pkg;

  typedef enum logic [1:0] {
    RES_ALU = 2'd0,
    RES_DM  = 2'd1,
    RES_PC  = 2'd2,
    RES_NW  = 2'd3
  } res_op_e;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_E    = 2'd1,
    FWD_M    = 2'd2,
    FWD_W    = 2'd3
  } fwd_e;

  // Largest 2-bit value: never strictly below any Tnew, so it never stalls.
  localparam logic [1:0] TUSE_NONE = 2'd3;

  function automatic logic [1:0] tuse_rs(input logic rs0, input logic rs1);
    if (rs0)      return 2'd0;
    else if (rs1) return 2'd1;
    else          return TUSE_NONE;
  endfunction

  function automatic logic [1:0] tuse_rt(input logic rt0, input logic rt1,
                                         input logic rt2);
    if (rt0)      return 2'd0;
    else if (rt1) return 2'd1;
    else if (rt2) return 2'd2;
    else          return TUSE_NONE;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/at_hazard_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | at_hazard_if : decode fields in, stall / bypass selects out        |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface at_hazard_if;
  logic [4:0] A1D;
  logic [4:0] A2D;
  logic [4:0] A3D;
  logic [1:0] resOpD;
  logic       Tuse_rs0;
  logic       Tuse_rs1;
  logic       Tuse_rt0;
  logic       Tuse_rt1;
  logic       Tuse_rt2;
  logic       stall;
  logic [1:0] FwdRsD;
  logic [1:0] FwdRtD;
  logic [1:0] FwdRsE;
  logic [1:0] FwdRtE;
  logic       FwdRtM;
  logic [4:0] A3E;
  logic [4:0] A3M;
  logic [4:0] A3W;

  modport master (
    output A1D, A2D, A3D, resOpD,
    output Tuse_rs0, Tuse_rs1, Tuse_rt0, Tuse_rt1, Tuse_rt2,
    input  stall, FwdRsD, FwdRtD, FwdRsE, FwdRtE, FwdRtM,
    input  A3E, A3M, A3W
  );

  modport slave (
    input  A1D, A2D, A3D, resOpD,
    input  Tuse_rs0, Tuse_rs1, Tuse_rt0, Tuse_rt1, Tuse_rt2,
    output stall, FwdRsD, FwdRtD, FwdRsE, FwdRtE, FwdRtM,
    output A3E, A3M, A3W
  );
endinterface
`default_nettype wire

// File: rtl/at_hazard_unit_stage_reg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | at_stage_reg : one shadow pipeline stage (rt, dest, Tnew)          |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module at_stage_reg
  import at_hazard_pkg::*;
#(
  parameter bit DEC_ON_LOAD = 1'b0
) (
  input  wire logic       clk,
  input  wire logic       reset,
  input  wire logic       bubble,
  input  wire logic [4:0] a2_in,
  input  wire logic [4:0] a3_in,
  input  wire logic [1:0] tnew_in,
  output logic      [4:0] a2_q,
  output logic      [4:0] a3_q,
  output logic      [1:0] tnew_q
);

  logic [1:0] tnew_next;

  // A stage fed by an older stage ages the countdown by one cycle on load.
  generate
    if (DEC_ON_LOAD) begin : g_dec
      assign tnew_next = sat_dec(tnew_in);
    end else begin : g_pass
      assign tnew_next = tnew_in;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      a2_q   <= 5'd0;
      a3_q   <= 5'd0;
      tnew_q <= 2'd0;
    end else begin
      a2_q   <= a2_in;
      a3_q   <= a3_in;
      tnew_q <= tnew_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/at_hazard_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | at_hazard_unit : E/M/W writer tracking, stall and bypass selection |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module at_hazard_unit
  import at_hazard_pkg::*;
#(
  parameter logic [1:0] TNEW_ALU = 2'd1,
  parameter logic [1:0] TNEW_DM  = 2'd2,
  parameter logic [1:0] TNEW_PC  = 2'd0
) (
  input  wire logic  clk,
  input  wire logic  reset,
  at_hazard_if.slave bus
);

  logic [1:0] tnew_d;
  logic [4:0] a3_track_d;
  logic [1:0] tuse_rs_d;
  logic [1:0] tuse_rt_d;

  logic [4:0] a1_e;
  logic [4:0] a2_e;
  logic [4:0] a3_e;
  logic [1:0] tnew_e;
  logic [4:0] a2_m;
  logic [4:0] a3_m;
  logic [1:0] tnew_m;
  logic [4:0] a3_w;

  logic       stall_rs;
  logic       stall_rt;
  logic       stall;

  always_comb begin
    tnew_d = 2'd0;
    case (bus.resOpD)
      RES_ALU: tnew_d = TNEW_ALU;
      RES_DM:  tnew_d = TNEW_DM;
      RES_PC:  tnew_d = TNEW_PC;
      default: tnew_d = 2'd0;
    endcase
  end

  assign a3_track_d = (bus.resOpD == RES_NW) ? 5'd0 : bus.A3D;
  assign tuse_rs_d  = tuse_rs(bus.Tuse_rs0, bus.Tuse_rs1);
  assign tuse_rt_d  = tuse_rt(bus.Tuse_rt0, bus.Tuse_rt1, bus.Tuse_rt2);

  function automatic logic hit(input logic [4:0] addr, input logic [4:0] dest);
    return (addr != 5'd0) && (addr == dest);
  endfunction

  // Youngest matching stage wins; a match that is not yet ready blocks older stages.
  function automatic logic [1:0] fwd_sel(input logic hit_e, input logic rdy_e,
                                         input logic hit_m, input logic rdy_m,
                                         input logic hit_w);
    if (hit_e)      return rdy_e ? FWD_E : FWD_NONE;
    else if (hit_m) return rdy_m ? FWD_M : FWD_NONE;
    else if (hit_w) return FWD_W;
    else            return FWD_NONE;
  endfunction

  assign stall_rs = (hit(bus.A1D, a3_e) && (tuse_rs_d < tnew_e)) ||
                    (hit(bus.A1D, a3_m) && (tuse_rs_d < tnew_m));
  assign stall_rt = (hit(bus.A2D, a3_e) && (tuse_rt_d < tnew_e)) ||
                    (hit(bus.A2D, a3_m) && (tuse_rt_d < tnew_m));
  assign stall    = stall_rs || stall_rt;

  always_ff @(posedge clk) begin
    if (reset || stall) begin
      a1_e <= 5'd0;
    end else begin
      a1_e <= bus.A1D;
    end
  end

  at_stage_reg #(.DEC_ON_LOAD(1'b0)) u_stage_e (
    .clk     (clk),
    .reset   (reset),
    .bubble  (stall),
    .a2_in   (bus.A2D),
    .a3_in   (a3_track_d),
    .tnew_in (tnew_d),
    .a2_q    (a2_e),
    .a3_q    (a3_e),
    .tnew_q  (tnew_e)
  );

  at_stage_reg #(.DEC_ON_LOAD(1'b1)) u_stage_m (
    .clk     (clk),
    .reset   (reset),
    .bubble  (1'b0),
    .a2_in   (a2_e),
    .a3_in   (a3_e),
    .tnew_in (tnew_e),
    .a2_q    (a2_m),
    .a3_q    (a3_m),
    .tnew_q  (tnew_m)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      a3_w <= 5'd0;
    end else begin
      a3_w <= a3_m;
    end
  end

  assign bus.stall  = stall;
  assign bus.FwdRsD = fwd_sel(hit(bus.A1D, a3_e), tnew_e == 2'd0,
                              hit(bus.A1D, a3_m), tnew_m == 2'd0,
                              hit(bus.A1D, a3_w));
  assign bus.FwdRtD = fwd_sel(hit(bus.A2D, a3_e), tnew_e == 2'd0,
                              hit(bus.A2D, a3_m), tnew_m == 2'd0,
                              hit(bus.A2D, a3_w));
  assign bus.FwdRsE = fwd_sel(1'b0, 1'b0,
                              hit(a1_e, a3_m), tnew_m == 2'd0,
                              hit(a1_e, a3_w));
  assign bus.FwdRtE = fwd_sel(1'b0, 1'b0,
                              hit(a2_e, a3_m), tnew_m == 2'd0,
                              hit(a2_e, a3_w));
  assign bus.FwdRtM = hit(a2_m, a3_w);
  assign bus.A3E    = a3_e;
  assign bus.A3M    = a3_m;
  assign bus.A3W    = a3_w;

endmodule
`default_nettype wire

// File: tb/tb_at_hazard_unit.sv
`default_nettype none
// Bench for at_hazard_unit: directed hazard scenarios with literal expectations,
// then random decode traffic checked every cycle against an in-flight instruction model.
module tb_at_hazard_unit;
  import at_hazard_pkg::*;

  localparam int TNEW_ALU_M = 1;
  localparam int TNEW_DM_M  = 2;
  localparam int TNEW_PC_M  = 0;
  localparam int OP_ALU = 0, OP_DM = 1, OP_PC = 2, OP_NW = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  bit   cmp_en = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  at_hazard_if bus();

  at_hazard_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // In-flight instructions: index 0 = E, 1 = M, 2 = W; tnew is the value at E entry.
  typedef struct {
    int a1;
    int a2;
    int a3;
    int tnew;
  } slot_t;
  slot_t pipe[3];

  function automatic int tnew_of(int op);
    case (op)
      OP_ALU:  return TNEW_ALU_M;
      OP_DM:   return TNEW_DM_M;
      OP_PC:   return TNEW_PC_M;
      default: return 0;
    endcase
  endfunction

  // Cycles still to wait before the instruction in stage k has its result.
  function automatic int remain(int k);
    int r;
    r = pipe[k].tnew - k;
    return (r < 0) ? 0 : r;
  endfunction

  function automatic int use_rs();
    if (bus.Tuse_rs0) return 0;
    if (bus.Tuse_rs1) return 1;
    return 99;
  endfunction

  function automatic int use_rt();
    if (bus.Tuse_rt0) return 0;
    if (bus.Tuse_rt1) return 1;
    if (bus.Tuse_rt2) return 2;
    return 99;
  endfunction

  function automatic bit m_stall();
    bit s;
    s = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (int'(bus.A1D) != 0 && int'(bus.A1D) == pipe[k].a3 && use_rs() < remain(k)) s = 1'b1;
      if (int'(bus.A2D) != 0 && int'(bus.A2D) == pipe[k].a3 && use_rt() < remain(k)) s = 1'b1;
    end
    return s;
  endfunction

  function automatic int m_fwd(int addr, int first);
    for (int k = first; k < 3; k++) begin
      if (addr != 0 && addr == pipe[k].a3) return (remain(k) == 0) ? k + 1 : 0;
    end
    return 0;
  endfunction

  function automatic int m_fwd_rtm();
    return (pipe[1].a2 != 0 && pipe[1].a2 == pipe[2].a3) ? 1 : 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    slot_t d;
    bit    st;
    if (reset) begin
      for (int k = 0; k < 3; k++) pipe[k] = '{0, 0, 0, 0};
    end else begin
      st     = m_stall();
      d.a1   = int'(bus.A1D);
      d.a2   = int'(bus.A2D);
      d.a3   = (int'(bus.resOpD) == OP_NW) ? 0 : int'(bus.A3D);
      d.tnew = tnew_of(int'(bus.resOpD));
      if (st) d = '{0, 0, 0, 0};
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = d;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("stall",  bus.stall,  m_stall());
      check("FwdRsD", bus.FwdRsD, m_fwd(int'(bus.A1D), 0));
      check("FwdRtD", bus.FwdRtD, m_fwd(int'(bus.A2D), 0));
      check("FwdRsE", bus.FwdRsE, m_fwd(pipe[0].a1, 1));
      check("FwdRtE", bus.FwdRtE, m_fwd(pipe[0].a2, 1));
      check("FwdRtM", bus.FwdRtM, m_fwd_rtm());
      check("A3E",    bus.A3E,    pipe[0].a3);
      check("A3M",    bus.A3M,    pipe[1].a3);
      check("A3W",    bus.A3W,    pipe[2].a3);
    end
  end

  task automatic drive(input int a1, input int a2, input int a3, input int op,
                       input bit rs0, input bit rs1, input bit rt0, input bit rt1,
                       input bit rt2);
    @(posedge clk);
    #1;
    bus.A1D      = 5'(a1);
    bus.A2D      = 5'(a2);
    bus.A3D      = 5'(a3);
    bus.resOpD   = 2'(op);
    bus.Tuse_rs0 = rs0;
    bus.Tuse_rs1 = rs1;
    bus.Tuse_rt0 = rt0;
    bus.Tuse_rt1 = rt1;
    bus.Tuse_rt2 = rt2;
    #2;
  endtask

  task automatic drive_rand();
    drive($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 3), 1'($urandom), 1'($urandom), 1'($urandom),
          1'($urandom), 1'($urandom));
  endtask

  task automatic nop();
    drive(0, 0, 0, OP_NW, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bus.A1D = '0; bus.A2D = '0; bus.A3D = '0; bus.resOpD = '0;
    bus.Tuse_rs0 = 0; bus.Tuse_rs1 = 0;
    bus.Tuse_rt0 = 0; bus.Tuse_rt1 = 0; bus.Tuse_rt2 = 0;

    // Reset held two cycles under arbitrary decode traffic.
    reset = 1'b1;
    drive_rand();
    cmp_en = 1'b1;
    drive(1, 1, 1, OP_DM, 0, 1, 0, 0, 0);
    check("rst_stall", bus.stall, 0);
    check("rst_fwd", {bus.FwdRsD, bus.FwdRtD, bus.FwdRsE, bus.FwdRtE, 1'b0, bus.FwdRtM}, 0);
    check("rst_a3", {bus.A3E, bus.A3M, bus.A3W}, 0);
    reset = 1'b0;

    // lw $1 ; addu $2,$1,$3
    nop();
    drive(0, 1, 1, OP_DM, 0, 1, 0, 0, 0);
    drive(1, 3, 2, OP_ALU, 0, 1, 0, 1, 0);
    check("lwuse_stall1", bus.stall, 1);
    drive(1, 3, 2, OP_ALU, 0, 1, 0, 1, 0);
    check("lwuse_stall2", bus.stall, 0);
    nop();
    check("lwuse_FwdRsE", bus.FwdRsE, 3);

    // addu $5 ; beq $5,$5
    nop(); nop();
    drive(0, 0, 5, OP_ALU, 0, 1, 0, 1, 0);
    drive(5, 5, 0, OP_NW, 1, 0, 1, 0, 0);
    check("beq_stall1", bus.stall, 1);
    drive(5, 5, 0, OP_NW, 1, 0, 1, 0, 0);
    check("beq_stall2", bus.stall, 0);
    check("beq_FwdRsD", bus.FwdRsD, 2);
    check("beq_FwdRtD", bus.FwdRtD, 2);

    // jal ; jr $31
    nop(); nop();
    drive(0, 0, 31, OP_PC, 0, 0, 0, 0, 0);
    drive(31, 0, 0, OP_NW, 1, 0, 0, 0, 0);
    check("jr_stall", bus.stall, 0);
    check("jr_FwdRsD", bus.FwdRsD, 1);

    // lw $4 ; sw $4,0($5)
    nop(); nop();
    drive(0, 4, 4, OP_DM, 0, 1, 0, 0, 0);
    drive(5, 4, 0, OP_NW, 0, 1, 0, 0, 1);
    check("sw_stall", bus.stall, 0);
    nop();
    nop();
    check("sw_FwdRtM", bus.FwdRtM, 1);

    // ori $0 ; addu $6,$0,$0
    nop(); nop();
    drive(0, 0, 0, OP_ALU, 0, 1, 0, 0, 0);
    drive(0, 0, 6, OP_ALU, 0, 1, 0, 1, 0);
    check("zero_stall", bus.stall, 0);
    check("zero_fwd", {bus.FwdRsD, bus.FwdRtD, bus.FwdRsE, bus.FwdRtE, 1'b0, bus.FwdRtM}, 0);

    // Reset pulsed during a load-use stall.
    nop(); nop();
    drive(0, 1, 1, OP_DM, 0, 1, 0, 0, 0);
    drive(1, 3, 2, OP_ALU, 0, 1, 0, 1, 0);
    check("rstmid_pre", bus.stall, 1);
    reset = 1'b1;
    drive(1, 3, 2, OP_ALU, 0, 1, 0, 1, 0);
    check("rstmid_stall", bus.stall, 0);
    check("rstmid_a3", {bus.A3E, bus.A3M}, 0);
    reset = 1'b0;

    // Random decode traffic with occasional reset.
    for (int i = 0; i < 800; i++) begin
      drive_rand();
      reset = ($urandom_range(0, 39) == 0);
    end
    reset = 1'b0;
    nop();

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/at_hazard_unit.md
Name: at_hazard_unit

Overview:
- Consumes the D-stage decode fields (register addresses, Tuse class flags, result-source code), tracks every in-flight writer through E/M/W, and issues stall plus forwarding selects.
- Holds the E/M/W shadow copies of A1/A2/A3 and a per-stage Tnew countdown.
- Sits beside the main pipeline registers. Its stall output freezes PC and IF/ID and inserts an E-stage bubble. Its forward selects drive the datapath bypass muxes.

Parameters:
- TNEW_ALU, 1, cycles after E entry until an ALU result is forwardable
- TNEW_DM, 2, cycles after E entry until load data is forwardable
- TNEW_PC, 0, cycles after E entry until the link value (PC+8) is forwardable

Ports:
- clk  in  1  clock
- reset  in  1  reset
- A1D  in  5  rs address of the D-stage instruction
- A2D  in  5  rt address of the D-stage instruction
- A3D  in  5  destination register of the D-stage instruction (0 = no write)
- resOpD  in  2  result source: ALU, DM, PC, NW
- Tuse_rs0, Tuse_rs1  in  1 each  rs needed at D / at E
- Tuse_rt0, Tuse_rt1, Tuse_rt2  in  1 each  rt needed at D / at E / at M
- stall  out  1  freeze PC and IF/ID, bubble into ID/EX
- FwdRsD, FwdRtD  out  2 each  D-stage bypass select
- FwdRsE, FwdRtE  out  2 each  E-stage bypass select
- FwdRtM  out  1  M-stage store-data bypass from W
- A3E, A3M, A3W  out  5 each  tracked destinations, for the datapath write-back and debug

Behaviour:
- Reset (clk and reset as named above): one clock; reset is synchronous and active-high. All internal state clears on the reset edge, including A1E, A2E, A3E, TnewE, A2M, A3M, TnewM, A3W. With all state clear, stall=0 and every Fwd output is 0.
- Reset asserted mid-stall drops stall on the next cycle and leaves no residual bubble state.
- Tnew encoding at D: ALU→TNEW_ALU, DM→TNEW_DM, PC→TNEW_PC, NW→0, 2 bits wide.
- Tracked destination: resOpD=NW forces the tracked destination to 0 regardless of A3D.
- Advance every cycle:
  - W ← M: A3W ← A3M.
  - M ← E: A2M ← A2E, A3M ← A3E, TnewM ← saturating (TnewE−1), floor 0.
  - E ← D, or bubble when stall=1. Bubble: A1E=A2E=A3E=0, TnewE=0.
- Tuse derivation (combinational): TuseRs = 0 if rs0, else 1 if rs1, else none. TuseRt = 0 / 1 / 2 by rt0 / rt1 / rt2, else none.
- "none" never causes a stall. When several flags are set, the smallest Tuse wins.
- Stall (combinational, same cycle). For X in {rs, rt}, with addr = A1D for rs and A2D for rt:
  - stall if addr≠0 and addr==A3E and TuseX < TnewE, or
  - addr≠0 and addr==A3M and TuseX < TnewM.
  - W never stalls.
- Forward select codes: 0 = regfile/pipe value, 1 = E, 2 = M, 3 = W.
- FwdRsD/FwdRtD: compare A1D/A2D against E, then M, then W. Pick the youngest stage with a nonzero matching address.
- FwdRsE/FwdRtE: compare A1E/A2E against M, then W.
- FwdRtM = (A2M≠0 and A2M==A3W).
- Selecting a stage: if the chosen stage's Tnew≠0, output 0 and do not fall through to an older stage. The stall guarantees that value is unused.
- $0 never matches any stage.

Decomposition:
- Shared define header: resOp codes (ALU=0, DM=1, PC=2, NW=3) and Fwd codes (NONE=0, E=1, M=2, W=3). Extend the existing define header; do not duplicate it.
- One sub-module, at_stage_reg: a single shadow stage (addresses plus Tnew) with bubble and saturating decrement. Instantiated for E and M; W is a plain 5-bit register.

Test Plan:
- Reset held 2 cycles with arbitrary D inputs → stall=0, all Fwd=0, A3E=A3M=A3W=0.
- lw $1 then addu $2,$1,$3 (Tuse_rs1) → stall=1 for exactly one cycle (TnewE=2>1). Next cycle stall=0 (TnewM=1). When addu is in E and lw is in W, FwdRsE=3.
- addu $5,… then beq $5,$5 (rs0, rt0) → one stall cycle. Then FwdRsD=2 and FwdRtD=2 (M, TnewM=0).
- jal then jr $31 → no stall, FwdRsD=1 (E, TNEW_PC=0).
- lw $4 then sw $4,0($5) (rt2, rs1) → no stall. When sw is in M and lw is in W, FwdRtM=1.
- ori $0 then addu $6,$0,$0 → stall=0, all Fwd=0. Also: reset pulsed during a lw-use stall → stall=0 next cycle and E/M cleared.
